// File: rtl/branch_checkpoint_queue_if.sv
// Rename/ROB-facing signal bundle for the branch checkpoint queue.
// master = rename/ROB side, slave = the queue itself.
interface branch_checkpoint_queue_if #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int TAG_W  = 5,
  parameter int PR_W   = 7,
  parameter int NUM_PR = 128,
  parameter int RN_W   = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 alloc_valid;
  logic [PC_W-1:0]      alloc_pc;
  logic [TAG_W-1:0]     alloc_rob_tag;
  logic                 alloc_ready;
  logic [RN_W-1:0]      nr_valid;
  logic [RN_W*PR_W-1:0] nr_pr;
  logic                 resolve_valid;
  logic                 resolve_mispredict;
  logic [TAG_W-1:0]     resolve_rob_tag;
  logic                 restore_valid;
  logic [PC_W-1:0]      restore_pc;
  logic [TAG_W-1:0]     restore_rob_tag;
  logic [NUM_PR-1:0]    restore_rdy_mask;
  logic                 resolve_miss;
  logic [CNT_W-1:0]     count;
  logic                 empty;

  modport master (
    output alloc_valid, alloc_pc, alloc_rob_tag, nr_valid, nr_pr,
           resolve_valid, resolve_mispredict, resolve_rob_tag,
    input  alloc_ready, restore_valid, restore_pc, restore_rob_tag,
           restore_rdy_mask, resolve_miss, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rob_tag, nr_valid, nr_pr,
           resolve_valid, resolve_mispredict, resolve_rob_tag,
    output alloc_ready, restore_valid, restore_pc, restore_rob_tag,
           restore_rdy_mask, resolve_miss, count, empty
  );
endinterface

// File: rtl/branch_checkpoint_queue.sv
// Age-ordered circular store of branch checkpoints (PC, ROB tag, not-ready PR mask)
// with mispredict restore/flush and in-order retire of resolved entries.
module branch_checkpoint_queue #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int TAG_W  = 5,
  parameter int PR_W   = 7,
  parameter int NUM_PR = 128,
  parameter int RN_W   = 2
) (
  input logic clk,
  input logic reset,
  branch_checkpoint_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  res_q;
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [NUM_PR-1:0] mask_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DEPTH-1:0]  match_p0;
  logic              any_p0;
  logic [PTR_W-1:0]  m_idx_p0;
  logic [PTR_W-1:0]  m_dist_p0;
  logic [PTR_W-1:0]  age_p0 [DEPTH];
  logic [DEPTH-1:0]  kill_p0;
  logic [NUM_PR-1:0] nr_bits_p0;
  logic              ready_p0;
  logic              mispred_req_p0;
  logic              flush_p0;
  logic              hit_p0;
  logic              alloc_fire_p0;
  logic              retire_p0;

  // Stage p0: lookup, flush range and per-cycle event decode from registered state
  always_comb begin
    match_p0 = '0;
    any_p0   = 1'b0;
    m_idx_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !res_q[i] && tag_q[i] == bus.resolve_rob_tag) begin
        match_p0[i] = 1'b1;
        any_p0      = 1'b1;
        m_idx_p0    = PTR_W'(i);
      end
    end
  end

  always_comb begin
    nr_bits_p0 = '0;
    for (int l = 0; l < RN_W; l++) begin
      if (bus.nr_valid[l]) nr_bits_p0[bus.nr_pr[l*PR_W +: PR_W]] = 1'b1;
    end
  end

  assign ready_p0       = (cnt_q != CNT_W'(DEPTH));
  assign mispred_req_p0 = bus.resolve_valid && bus.resolve_mispredict;
  assign flush_p0       = mispred_req_p0 && any_p0;
  assign hit_p0         = bus.resolve_valid && !bus.resolve_mispredict && any_p0;
  assign alloc_fire_p0  = bus.alloc_valid && ready_p0 && !mispred_req_p0;
  assign retire_p0      = vld_q[head_q] && res_q[head_q];
  assign m_dist_p0      = m_idx_p0 - head_q;

  // Age relative to head: the mispredicted entry and everything at least as young dies
  always_comb begin
    kill_p0 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_p0[i]  = PTR_W'(i) - head_q;
      kill_p0[i] = flush_p0 && (age_p0[i] >= m_dist_p0);
    end
  end

  assign bus.alloc_ready = ready_p0;
  assign bus.count       = cnt_q;
  assign bus.empty       = (cnt_q == '0);

  // Stage p1: state update and registered restore/miss pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q                <= '0;
      res_q                <= '0;
      head_q               <= '0;
      tail_q               <= '0;
      cnt_q                <= '0;
      bus.restore_valid    <= 1'b0;
      bus.restore_pc       <= '0;
      bus.restore_rob_tag  <= '0;
      bus.restore_rdy_mask <= '0;
      bus.resolve_miss     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        tag_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      bus.restore_valid <= flush_p0;
      bus.resolve_miss  <= bus.resolve_valid && !any_p0;
      if (flush_p0) begin
        bus.restore_pc       <= pc_q[m_idx_p0];
        bus.restore_rob_tag  <= tag_q[m_idx_p0];
        bus.restore_rdy_mask <= mask_q[m_idx_p0];
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (kill_p0[i] || (retire_p0 && head_q == PTR_W'(i))) begin
          vld_q[i] <= 1'b0;
          res_q[i] <= 1'b0;
        end else begin
          if (hit_p0 && match_p0[i]) res_q[i] <= 1'b1;
          if (!flush_p0 && vld_q[i]) mask_q[i] <= mask_q[i] | nr_bits_p0;
          if (alloc_fire_p0 && tail_q == PTR_W'(i)) begin
            vld_q[i]  <= 1'b1;
            res_q[i]  <= 1'b0;
            pc_q[i]   <= bus.alloc_pc;
            tag_q[i]  <= bus.alloc_rob_tag;
            mask_q[i] <= '0;
          end
        end
      end

      if (retire_p0) head_q <= head_q + 1'b1;
      if (flush_p0) tail_q <= m_idx_p0;
      else if (alloc_fire_p0) tail_q <= tail_q + 1'b1;

      if (flush_p0) cnt_q <= CNT_W'(m_dist_p0) - CNT_W'(retire_p0);
      else          cnt_q <= cnt_q + CNT_W'(alloc_fire_p0) - CNT_W'(retire_p0);
    end
  end
endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Directed scoreboard bench: expected restore/miss pulses are queued by the stimulus
// and consumed by an independent monitor; queue occupancy is checked inline.
module tb_branch_checkpoint_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_checkpoint_queue_if bus ();
  branch_checkpoint_queue dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit          miss;
    logic [31:0] pc;
    logic [4:0]  tag;
    logic [127:0] mask;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && (bus.restore_valid || bus.resolve_miss)) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: restore_valid=%0b resolve_miss=%0b expected none",
                 bus.restore_valid, bus.resolve_miss);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 128'({bus.restore_valid, bus.resolve_miss}), e.miss ? 128'd1 : 128'd2);
        if (!e.miss) begin
          chk("restore_pc", 128'(bus.restore_pc), 128'(e.pc));
          chk("restore_tag", 128'(bus.restore_rob_tag), 128'(e.tag));
          chk("restore_mask", bus.restore_rdy_mask, e.mask);
        end
      end
    end
  end

  task automatic idle();
    bus.alloc_valid        = 1'b0;
    bus.alloc_pc           = '0;
    bus.alloc_rob_tag      = '0;
    bus.nr_valid           = '0;
    bus.nr_pr              = '0;
    bus.resolve_valid      = 1'b0;
    bus.resolve_mispredict = 1'b0;
    bus.resolve_rob_tag    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    idle();
  endtask

  task automatic alloc(input logic [4:0] tag, input logic [31:0] pc);
    bus.alloc_valid   = 1'b1;
    bus.alloc_rob_tag = tag;
    bus.alloc_pc      = pc;
    cyc();
    idle();
  endtask

  task automatic push_restore(input logic [31:0] pc, input logic [4:0] tag, input logic [127:0] mask);
    exp_t e;
    e.miss = 1'b0; e.pc = pc; e.tag = tag; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic push_miss();
    exp_t e;
    e.miss = 1'b1; e.pc = '0; e.tag = '0; e.mask = '0;
    sb.push_back(e);
  endtask

  task automatic drained(input string name);
    @(negedge clk);
    #1;
    chk(name, 128'(sb.size()), 128'd0);
  endtask

  task automatic resolve(input bit mp, input logic [4:0] tag);
    bus.resolve_valid      = 1'b1;
    bus.resolve_mispredict = mp;
    bus.resolve_rob_tag    = tag;
    cyc();
    idle();
    drained("pulse_timing");
  endtask

  logic [127:0] m;

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    chk("reset_count", 128'(bus.count), 128'd0);
    chk("reset_ready", 128'(bus.alloc_ready), 128'd1);
    chk("reset_empty", 128'(bus.empty), 128'd1);
    chk("reset_restore_valid", 128'(bus.restore_valid), 128'd0);
    chk("reset_restore_pc", 128'(bus.restore_pc), 128'd0);
    chk("reset_miss", 128'(bus.resolve_miss), 128'd0);

    // 1: fill to capacity, extra request ignored
    for (int i = 1; i <= 8; i++) alloc(5'(i), 32'h100 + 32'(4 * (i - 1)));
    chk("fill_count", 128'(bus.count), 128'd8);
    chk("fill_ready", 128'(bus.alloc_ready), 128'd0);
    alloc(5'd9, 32'h120);
    chk("overfill_count", 128'(bus.count), 128'd8);
    do_reset();
    chk("reset2_empty", 128'(bus.empty), 128'd1);

    // 2: mask accumulation then mispredict of the only entry
    alloc(5'd3, 32'h200);
    bus.nr_valid = 2'b11;
    bus.nr_pr    = {7'd40, 7'd9};
    cyc();
    idle();
    m = '0; m[9] = 1'b1; m[40] = 1'b1;
    push_restore(32'h200, 5'd3, m);
    resolve(1'b1, 5'd3);
    chk("mp_count", 128'(bus.count), 128'd0);
    chk("mp_empty", 128'(bus.empty), 128'd1);

    // 3: partial flush, slot reuse
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 32'h300 + 32'(4 * (i - 1)));
    push_restore(32'h304, 5'd2, '0);
    resolve(1'b1, 5'd2);
    chk("pflush_count", 128'(bus.count), 128'd1);
    alloc(5'd5, 32'h400);
    chk("pflush_realloc_count", 128'(bus.count), 128'd2);
    push_restore(32'h400, 5'd5, '0);
    resolve(1'b1, 5'd5);
    chk("pflush_second_count", 128'(bus.count), 128'd1);
    push_miss();
    resolve(1'b0, 5'd2);
    chk("flushed_tag_miss_count", 128'(bus.count), 128'd1);

    // 4: in-order retire
    do_reset();
    for (int i = 1; i <= 3; i++) alloc(5'(i), 32'h500 + 32'(4 * (i - 1)));
    resolve(1'b0, 5'd2);
    chk("ret_hold_a", 128'(bus.count), 128'd3);
    cyc();
    chk("ret_hold_b", 128'(bus.count), 128'd3);
    resolve(1'b0, 5'd1);
    chk("ret_no_early", 128'(bus.count), 128'd3);
    cyc();
    chk("ret_first", 128'(bus.count), 128'd2);
    cyc();
    chk("ret_second", 128'(bus.count), 128'd1);
    cyc();
    chk("ret_settled", 128'(bus.count), 128'd1);
    push_miss();
    resolve(1'b0, 5'd2);
    push_restore(32'h508, 5'd3, '0);
    resolve(1'b1, 5'd3);
    chk("ret_head_flush_empty", 128'(bus.empty), 128'd1);

    // 5: wrap with concurrent hit/alloc, then mispredict drops alloc
    do_reset();
    for (int i = 1; i <= 6; i++) alloc(5'(i), 32'h600 + 32'(4 * (i - 1)));
    for (int i = 1; i <= 6; i++) resolve(1'b0, 5'(i));
    repeat (3) cyc();
    chk("wrap_drained", 128'(bus.count), 128'd0);
    alloc(5'd7, 32'h700);
    chk("wrap_a", 128'(bus.count), 128'd1);
    bus.alloc_valid = 1'b1; bus.alloc_rob_tag = 5'd8; bus.alloc_pc = 32'h800;
    bus.resolve_valid = 1'b1; bus.resolve_mispredict = 1'b0; bus.resolve_rob_tag = 5'd7;
    cyc();
    idle();
    chk("wrap_alloc_hit", 128'(bus.count), 128'd2);
    bus.alloc_valid = 1'b1; bus.alloc_rob_tag = 5'd9; bus.alloc_pc = 32'h900;
    bus.nr_valid = 2'b01; bus.nr_pr = {7'd0, 7'd5};
    cyc();
    idle();
    chk("wrap_alloc_retire", 128'(bus.count), 128'd2);
    m = '0; m[5] = 1'b1;
    push_restore(32'h800, 5'd8, m);
    bus.alloc_valid = 1'b1; bus.alloc_rob_tag = 5'd10; bus.alloc_pc = 32'hA00;
    bus.resolve_valid = 1'b1; bus.resolve_mispredict = 1'b1; bus.resolve_rob_tag = 5'd8;
    cyc();
    idle();
    chk("mp_drops_alloc", 128'(bus.count), 128'd0);
    drained("wrap_restore");
    push_miss();
    resolve(1'b1, 5'd10);
    alloc(5'd11, 32'hB00);
    chk("post_wrap_alloc", 128'(bus.count), 128'd1);

    // 6: miss without state change, then reset under load
    do_reset();
    for (int i = 1; i <= 5; i++) alloc(5'(i), 32'hC00 + 32'(4 * (i - 1)));
    push_miss();
    resolve(1'b1, 5'd31);
    chk("miss_count", 128'(bus.count), 128'd5);
    bus.alloc_valid = 1'b1; bus.alloc_rob_tag = 5'd6; bus.alloc_pc = 32'hD00;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    idle();
    chk("midreset_empty", 128'(bus.empty), 128'd1);
    chk("midreset_count", 128'(bus.count), 128'd0);
    chk("midreset_restore", 128'(bus.restore_valid), 128'd0);
    cyc();
    chk("midreset_stay", 128'(bus.count), 128'd0);

    chk("sb_final", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_checkpoint_queue.md
Name: branch_checkpoint_queue

Overview:
- Parametrised, age-ordered branch checkpoint store for the rename/ROB recovery path. Successor to the fixed 4/8-slot checkpoint.
- Each in-flight branch gets a circular-queue entry holding PC, ROB tag and a per-checkpoint "physical registers made not-ready since this branch" mask.
- A mispredict returns that entry's snapshot and flushes it plus every younger entry.
- A correct resolution marks the entry resolved; resolved entries retire in order from the head.

Parameters:
- DEPTH, 8, number of checkpoints; power of two, >= 2
- PC_W, 32, branch PC width
- TAG_W, 5, ROB tag width
- PR_W, 7, physical register index width
- NUM_PR, 128, physical register count; equals 2**PR_W
- RN_W, 2, rename lanes that can mark a PR not-ready per cycle

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- alloc_valid  in  1  rename requests a checkpoint for a branch
- alloc_pc  in  PC_W  branch PC
- alloc_rob_tag  in  TAG_W  branch ROB tag
- alloc_ready  out  1  a free entry exists (count < DEPTH)
- nr_valid  in  RN_W  per-lane not-ready mark valid
- nr_pr  in  RN_W*PR_W  per-lane PR index; lane i is bits [i*PR_W +: PR_W]
- resolve_valid  in  1  ROB resolves a branch
- resolve_mispredict  in  1  1 = mispredict, 0 = correct (hit)
- resolve_rob_tag  in  TAG_W  tag of the resolved branch
- restore_valid  out  1  one-cycle pulse: restore fields are valid
- restore_pc  out  PC_W  snapshot PC
- restore_rob_tag  out  TAG_W  snapshot tag
- restore_rdy_mask  out  NUM_PR  PRs to force ready again
- resolve_miss  out  1  one-cycle pulse: resolve tag matched no live entry
- count  out  $clog2(DEPTH)+1  live entries
- empty  out  1  count == 0

Behaviour:
- **Entry state:** valid, resolved, pc, rob_tag, mask[NUM_PR]. Pointers head (oldest) and tail (next free), each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- **Reset** (reset==0 at an edge):
  - All entries cleared; head = tail = count = 0.
  - restore_valid = 0, restore_* = 0, resolve_miss = 0.
  - Therefore alloc_ready = 1 and empty = 1.
- **Derived outputs:** alloc_ready, count and empty come from registered state only. No input-to-output combinational path.
- **Allocate:**
  - Fires when alloc_valid && alloc_ready && !(resolve_valid && resolve_mispredict).
  - Writes entry[tail] = {valid=1, resolved=0, pc, tag, mask=0}; tail++, count++.
  - alloc_valid while !alloc_ready is ignored; the requester stalls.
- **Not-ready marking:**
  - For each lane i with nr_valid[i], set mask[nr_pr[i]] in every entry valid at the start of the cycle.
  - An entry allocated in the same cycle does not receive that cycle's bits.
  - No marking in a mispredict cycle.
  - Duplicate PRs across lanes are harmless (OR).
- **Lookup:** match = valid && !resolved && rob_tag == resolve_rob_tag. At most one match (tags are unique in flight).
- **Mispredict** (resolve_valid && resolve_mispredict, match at index m):
  - Next cycle: restore_valid = 1 with entry[m] pc/tag/mask as held at the start of the mispredict cycle.
  - Entry m and all younger entries (m..tail-1, wrapping) invalidated.
  - tail <= m; count <= (m - head) mod DEPTH.
  - If m == head, the queue becomes empty; older resolved-but-unretired entries are kept.
  - Any allocation that cycle is dropped.
- **Hit** (resolve_valid && !resolve_mispredict, match): entry.resolved <= 1. An allocation in the same cycle proceeds.
- **No match** on any resolve: resolve_miss = 1 next cycle, no state change, restore_valid stays 0.
- **Retire:**
  - Each cycle, if entry[head].valid && resolved (registered state), clear it and head++, count--. At most one retire per cycle.
  - Retire evaluates before a same-cycle mispredict flush; a retiring head is never the flushed entry because it is already resolved.
  - count arithmetic combines alloc (+1) and retire (-1) in the same cycle.
  - A resolve at cycle t can retire no earlier than t+1.
- restore_valid and resolve_miss are single-cycle pulses, 0 otherwise. restore_* hold their last values when restore_valid = 0.
- **Reset mid-operation:** reset overrides all concurrent alloc/resolve/mark activity that cycle.

Test Plan:
1. **Reset then fill:**
   - Stimulus: 8 allocs, tags 1..8, PCs 0x100..0x11C.
   - Required: count=8, alloc_ready=0; a 9th alloc_valid is ignored and count stays 8.
2. **Mask and mispredict:**
   - Stimulus: alloc tag 3; next cycle nr_valid=2'b11, nr_pr={7'd40,7'd9}; then mispredict tag 3.
   - Required: one cycle later restore_valid=1, restore_pc of tag 3, restore_rdy_mask has only bits 9 and 40 set; count=0.
3. **Partial flush:**
   - Stimulus: allocs tags 1,2,3,4; mispredict tag 2.
   - Required: count=1, only tag 1 live; next alloc lands in tag 2's old slot.
4. **In-order retire:**
   - Stimulus: allocs tags 1,2,3; hit tag 2, then hit tag 1.
   - Required: nothing retires while tag 1 is unresolved; afterwards tags 1 then 2 retire on consecutive cycles; count ends at 1.
5. **Wrap and simultaneous events:**
   - Stimulus: with head=6, alloc twice so tail wraps to 0; same cycle as an alloc, hit the head entry.
   - Required: both take effect, count correct across the wrap. A mispredict plus alloc in one cycle drops the alloc.
6. **Miss and mid-op reset:**
   - Stimulus: resolve tag 31, never allocated.
   - Required: resolve_miss pulses 1 cycle, no state change.
   - Stimulus: reset low while 5 entries are live plus a concurrent alloc.
   - Required: next cycle empty=1, restore_valid=0.
